// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MIPS_OVF_TRAP_EN adds the TRAP state used for signed-overflow exceptions.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BEQEX    = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
`ifdef MIPS_OVF_TRAP_EN
        S_JEX      = 4'd11,
        S_TRAP     = 4'd12
`else
        S_JEX      = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // aluop selects between fixed add/sub and the funct-driven R-type decode
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic fn_can_overflow(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB);
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps aluop plus funct to the 3-bit ALU function code.
// funct_illegal flags an unsupported funct only when aluop requests funct decode.
module alu_dec
    import mips_ctrl_pkg::*;
#(
    parameter int FNW = 6
) (
    input  logic [1:0]     aluop,
    input  logic [FNW-1:0] funct,
    output logic [2:0]     alucontrol,
    output logic           funct_illegal
);

    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        alucontrol    = ALU_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define MIPS_OVF_TRAP_EN to add the exc output and the overflow TRAP state.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    input  logic           overflow,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           memwrite,
    output logic           irwrite,
    output logic           iord,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic           pcen,
    output logic [2:0]     alucontrol,
    output logic           illegal,
    output logic           busy_fetch,
`ifdef MIPS_OVF_TRAP_EN
    output logic           exc,
`endif
    output logic [3:0]     dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  w_aluop;
    logic [2:0]  w_alu_ctrl;
    logic        w_funct_illegal;
    logic        w_mem_req;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_iord;
    logic        w_regdst;
    logic        w_memtoreg;
    logic        w_regwrite;
    logic        w_alusrca;
    logic [1:0]  w_alusrcb;
    logic [1:0]  w_pcsrc;
    logic        w_pcwrite;
    logic        w_branch;
    logic        w_illegal;
    logic        w_exc;

    alu_dec #(.FNW(FNW)) u_alu_dec (
        .aluop         (w_aluop),
        .funct         (funct),
        .alucontrol    (w_alu_ctrl),
        .funct_illegal (w_funct_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_aluop    = ALUOP_ADD;
        w_mem_req  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_iord     = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        w_exc      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_alusrcb = 2'b01;
                // IR load and PC+4 update only happen in the cycle the read completes
                if (mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_iord     = 1'b1;
                w_memwrite = mem_ready;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
                if (w_funct_illegal) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
`ifdef MIPS_OVF_TRAP_EN
                end else if (overflow && fn_can_overflow(funct)) begin
                    w_next = S_TRAP;
`endif
                end else begin
                    w_next = S_RTYPEWB;
                end
            end
            S_RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
                w_pcsrc   = 2'b01;
                w_next    = S_FETCH;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
`ifdef MIPS_OVF_TRAP_EN
                w_next    = overflow ? S_TRAP : S_ADDIWB;
`else
                w_next    = S_ADDIWB;
`endif
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JEX: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
`ifdef MIPS_OVF_TRAP_EN
            S_TRAP: begin
                w_exc  = 1'b1;
                w_next = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

`ifndef MIPS_OVF_TRAP_EN
    // Without the trap, overflow wraps silently and the flag has no consumer.
    logic w_unused_ovf;
    assign w_unused_ovf = overflow ^ w_exc;
`endif

    // Every output is forced low while reset is asserted, including FETCH's strobes.
    assign mem_req    = reset_n & w_mem_req;
    assign memwrite   = reset_n & w_memwrite;
    assign irwrite    = reset_n & w_irwrite;
    assign iord       = reset_n & w_iord;
    assign regdst     = reset_n & w_regdst;
    assign memtoreg   = reset_n & w_memtoreg;
    assign regwrite   = reset_n & w_regwrite;
    assign alusrca    = reset_n & w_alusrca;
    assign alusrcb    = reset_n ? w_alusrcb : 2'b00;
    assign pcsrc      = reset_n ? w_pcsrc : 2'b00;
    assign pcen       = reset_n & (w_pcwrite | (w_branch & zero));
    assign alucontrol = reset_n ? w_alu_ctrl : 3'b000;
    assign illegal    = reset_n & w_illegal;
    assign busy_fetch = reset_n & (r_state == S_FETCH);
`ifdef MIPS_OVF_TRAP_EN
    assign exc        = reset_n & w_exc;
`endif
    assign dbg_state  = r_state;

endmodule
